dmem_store_buffer: RTL and testbench

- Posted-write buffer between the CPU MEM-stage data port and the single-port data memory.
- Stores are queued in FIFO order and drained to memory on cycles with no load.
- Loads bypass the queue and receive forwarded data from the youngest matching buffered store; otherwise they receive memory read data.
- Lets stores retire in one cycle while loads keep priority on the memory port.

---
 rtl/dmem_store_buffer.sv | 111 +++++++++++
 tb/tb_dmem_store_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the MEM-stage data port and a single-port data memory.
// Stores retire in one cycle and drain on load-free cycles; loads forward from the youngest buffered store; full buffer stalls the CPU.
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_wen,
  input  logic                     cpu_ren,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     stall,
  output logic                     mem_wen,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full;
  logic              enq;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    enq   = cpu_wen & ~full;
    // Drain is suppressed during reset so discarded stores never reach memory.
    drain = (count_q != '0) & ~cpu_ren & ~rst;
  end

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[fwd_idx] == cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (drain) head_d = head_q + PTR_W'(1);
    case ({enq, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_wdata;
    end
  end

  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = '0;
    if (drain) begin
      mem_wen   = 1'b1;
      mem_addr  = addr_q[head_q];
      mem_wdata = data_q[head_q];
    end
  end

  always_comb begin
    stall     = cpu_wen & full;
    cpu_rdata = (cpu_ren && fwd_hit) ? fwd_data : mem_rdata;
    count     = count_q;
    empty     = (count_q == '0);
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: vector table, hand-written reset/wrap sequences, drain-order scoreboard.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wen;
  logic        cpu_ren;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  count;
  logic        empty;

  logic        init_mem;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t sb[$];

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic        xs;
    logic        xw;
    logic [31:0] xa;
    logic [31:0] xd;
    logic [31:0] xr;
    int          xc;
  } vec_t;
  vec_t tbl[$];

  dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_wen   (cpu_wen),
    .cpu_ren   (cpu_ren),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[13] <= 32'h55;
    end else if (mem_wen === 1'b1) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    cpu_wen   = w;
    cpu_ren   = r;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] a);
    logic [31:0] r;
    r = mem[a[9:2]];
    foreach (sb[k]) if (sb[k].a == a) r = sb[k].d;
    return r;
  endfunction

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                              input logic xs, input logic xw, input logic [31:0] xa,
                              input logic [31:0] xd, input logic [31:0] xr, input int xc);
    vec_t v;
    v.w = w; v.r = r; v.a = a; v.d = d;
    v.xs = xs; v.xw = xw; v.xa = xa; v.xd = xd; v.xr = xr; v.xc = xc;
    return v;
  endfunction

  // Every memory write must be the oldest outstanding store.
  task automatic monitor();
    ent_t e;
    forever begin
      @(negedge clk);
      if (mem_wen === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
        end else begin
          e = sb.pop_front();
          chk("drain_addr", mem_addr, e.a);
          chk("drain_data", mem_wdata, e.d);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        r;
    logic        xs;

    rst = 1'b1;
    init_mem = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF);
    fork
      monitor();
    join_none

    // Reset held for two cycles with a store presented.
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    rst = 1'b0;
    init_mem = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    //          w     r     addr    data     stall wen   maddr   mwdata   rdata  cnt
    tbl.push_back(mk(1'b1, 1'b0, 32'h10, 32'hA5,  1'b0, 1'b0, 32'h10, 32'h0,   32'h0,  0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 32'h10, 32'hA5,  32'h0,  1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 32'h0,  32'h0,   32'h0,  0));
    tbl.push_back(mk(1'b1, 1'b1, 32'h20, 32'h1,   1'b0, 1'b0, 32'h20, 32'h0,   32'h0,  0));
    tbl.push_back(mk(1'b1, 1'b1, 32'h20, 32'h2,   1'b0, 1'b0, 32'h20, 32'h0,   32'h1,  1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h20, 32'h0,   1'b0, 1'b0, 32'h20, 32'h0,   32'h2,  2));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 32'h20, 32'h1,   32'h0,  2));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 32'h20, 32'h2,   32'h0,  1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 32'h0,  32'h0,   32'h0,  0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h30, 32'h7,   1'b0, 1'b0, 32'h30, 32'h0,   32'h0,  0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h34, 32'h0,   1'b0, 1'b0, 32'h34, 32'h0,   32'h55, 1));
    tbl.push_back(mk(1'b0, 1'b1, 32'h30, 32'h0,   1'b0, 1'b0, 32'h30, 32'h0,   32'h7,  1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 32'h30, 32'h7,   32'h0,  1));
    tbl.push_back(mk(1'b1, 1'b1, 32'h40, 32'h400, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0,  0));
    tbl.push_back(mk(1'b1, 1'b1, 32'h44, 32'h440, 1'b0, 1'b0, 32'h44, 32'h0,   32'h0,  1));
    tbl.push_back(mk(1'b1, 1'b1, 32'h48, 32'h480, 1'b0, 1'b0, 32'h48, 32'h0,   32'h0,  2));
    tbl.push_back(mk(1'b1, 1'b1, 32'h4C, 32'h4C0, 1'b0, 1'b0, 32'h4C, 32'h0,   32'h0,  3));
    tbl.push_back(mk(1'b1, 1'b1, 32'h50, 32'h500, 1'b1, 1'b0, 32'h50, 32'h0,   32'h0,  4));
    tbl.push_back(mk(1'b1, 1'b0, 32'h50, 32'h500, 1'b1, 1'b1, 32'h40, 32'h400, 32'h0,  4));
    tbl.push_back(mk(1'b1, 1'b1, 32'h50, 32'h500, 1'b0, 1'b0, 32'h50, 32'h0,   32'h0,  3));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 32'h44, 32'h440, 32'h0,  4));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 32'h48, 32'h480, 32'h0,  3));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 32'h4C, 32'h4C0, 32'h0,  2));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 32'h50, 32'h500, 32'h0,  1));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 32'h0,  32'h0,   32'h0,  0));

    foreach (tbl[i]) begin
      drive(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].xs));
      chk($sformatf("v%0d_mem_wen", i), 32'(mem_wen), 32'(tbl[i].xw));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].xa);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].xc));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].xc == 0));
      if (tbl[i].r) chk($sformatf("v%0d_rdata", i), cpu_rdata, tbl[i].xr);
      else chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].xd);
      if (tbl[i].w && !tbl[i].xs) sb.push_back('{a: tbl[i].a, d: tbl[i].d});
      step();
    end

    // Ten stores over four repeating addresses, interleaved with loads and drains.
    for (int i = 0; i < 10; i++) begin
      a  = 32'h100 + 32'((i % 4) * 4);
      d  = $urandom;
      r  = (i % 2 == 0);
      xs = (sb.size() == DEPTH);
      drive(1'b1, r, a, d);
      #1;
      chk($sformatf("w%0d_store_stall", i), 32'(stall), 32'(xs));
      chk($sformatf("w%0d_store_count", i), 32'(count), 32'(sb.size()));
      chk($sformatf("w%0d_store_mem_wen", i), 32'(mem_wen), 32'(!r && sb.size() > 0));
      if (r) chk($sformatf("w%0d_store_rdata", i), cpu_rdata, exp_load(a));
      if (!xs) sb.push_back('{a: a, d: d});
      step();
      r = (i % 3 == 2);
      a = 32'h100 + 32'(((i + 1) % 4) * 4);
      drive(1'b0, r, a, 32'h0);
      #1;
      chk($sformatf("w%0d_b_count", i), 32'(count), 32'(sb.size()));
      chk($sformatf("w%0d_b_mem_wen", i), 32'(mem_wen), 32'(!r && sb.size() > 0));
      if (r) chk($sformatf("w%0d_b_rdata", i), cpu_rdata, exp_load(a));
      step();
    end
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      step();
    end
    chk("wrap_pending", 32'(sb.size()), 32'd0);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset with three stores pending: none may reach memory.
    for (int i = 0; i < 3; i++) begin
      a = 32'h200 + 32'(i * 4);
      drive(1'b1, 1'b1, a, 32'h11 + 32'(i));
      #1;
      chk($sformatf("r%0d_count", i), 32'(count), 32'(i));
      sb.push_back('{a: a, d: 32'h11 + 32'(i)});
      step();
    end
    chk("rmid_count3", 32'(count), 32'd3);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rmid_no_drain", 32'(mem_wen), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rmid_count", 32'(count), 32'd0);
    chk("rmid_empty", 32'(empty), 32'd1);
    for (int k = 0; k < 5; k++) step();
    chk("rmid_mem0", mem[128], 32'h0);
    chk("rmid_mem1", mem[129], 32'h0);
    chk("rmid_mem2", mem[130], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
